// File: rtl/fifo_param_pkg.sv
// Shared types and helpers for the fifo_param elastic buffer.
// Optional feature macro used by the top: FIFO_PARAM_HWM_EN (high-water-mark output).
package fifo_param_pkg;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Level counter must represent 0..DEPTH inclusive.
  function automatic int unsigned clog2_depth(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  // Explicit wrap so non-power-of-2 depths work.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    if (ptr == depth - 32'd1) begin
      return 32'd0;
    end else begin
      return ptr + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_param_ram.sv
// Storage array for fifo_param: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_param_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PW    = 5
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock show-ahead FIFO with level, thresholds, flush and sticky errors.
// Define FIFO_PARAM_HWM_EN to add the hwm (peak occupancy) output.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AF_THRESH = 28,
  parameter int unsigned AE_THRESH = 4,
  parameter int unsigned LW        = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] datain,
  input  logic             pull,
  output logic [WIDTH-1:0] dataout,
  input  logic             flush,
  input  logic             clr_err,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
`ifdef FIFO_PARAM_HWM_EN
  output logic [LW-1:0]    hwm,
`endif
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  err_flags_t       r_err;

  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [LW-1:0]    w_level_nxt;
  err_flags_t       w_err_nxt;
  logic             w_empty;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pull_ok;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty   = (r_level == {LW{1'b0}});
  assign w_full    = (r_level == LW'(DEPTH));
  // Flush wins over same-cycle traffic and suppresses error events.
  assign w_push_ok = push & ~w_full  & ~flush;
  assign w_pull_ok = pull & ~w_empty & ~flush;
  assign w_ovf_evt = push & w_full  & ~flush;
  assign w_unf_evt = pull & w_empty & ~flush;

  // Next-state for pointers, level and sticky flags
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_level_nxt  = r_level;
    if (flush) begin
      w_wr_ptr_nxt = {PW{1'b0}};
      w_rd_ptr_nxt = {PW{1'b0}};
      w_level_nxt  = {LW{1'b0}};
    end else begin
      if (w_push_ok) begin
        w_wr_ptr_nxt = PW'(next_ptr(32'(r_wr_ptr), DEPTH));
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pull_ok) begin
        w_rd_ptr_nxt = PW'(next_ptr(32'(r_rd_ptr), DEPTH));
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_push_ok, w_pull_ok})
        2'b10:   w_level_nxt = r_level + LW'(1);
        2'b01:   w_level_nxt = r_level - LW'(1);
        default: w_level_nxt = r_level;
      endcase
    end
    w_err_nxt.overflow  = w_ovf_evt | (r_err.overflow  & ~clr_err);
    w_err_nxt.underflow = w_unf_evt | (r_err.underflow & ~clr_err);
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_level  <= {LW{1'b0}};
      r_err    <= '{overflow: 1'b0, underflow: 1'b0};
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_err    <= w_err_nxt;
    end
  end

`ifdef FIFO_PARAM_HWM_EN
  logic [LW-1:0] r_hwm;

  // Peak occupancy; restarts from the current level after clr_err
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hwm <= {LW{1'b0}};
    end else if (flush) begin
      r_hwm <= {LW{1'b0}};
    end else if (clr_err) begin
      r_hwm <= w_level_nxt;
    end else if (w_level_nxt > r_hwm) begin
      r_hwm <= w_level_nxt;
    end else begin
      r_hwm <= r_hwm;
    end
  end

  assign hwm = r_hwm;
`endif

  fifo_param_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (datain),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign dataout      = w_empty ? {WIDTH{1'b0}} : w_rdata;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_level >= LW'(AF_THRESH));
  assign almost_empty = (r_level <= LW'(AE_THRESH));
  assign level        = r_level;
  assign overflow     = r_err.overflow;
  assign underflow    = r_err.underflow;

endmodule
